fft_bitrev_buf: RTL and testbench
=================================

# fft_bitrev_buf

Parametrised ping-pong reorder buffer between the last radix-2 butterfly stage and the FFT output port. Accepts complex samples in natural order, one frame of 2^LOG2N points at a time, and emits each frame in bit-reversed address order. Both sides use valid/ready handshakes. Two banks let one frame fill while the previous frame drains, sustaining one sample per cycle.

## Interface
- DW, 16, width of each real/imaginary component (two's complement)
- LOG2N, 6, log2 of frame length N (N = 64 by default); legal range 2..10
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input sample valid
- in_ready  output  1  buffer can accept a sample
- in_re, in_im  input  DW each  input sample, natural order
- out_valid  output  1  output sample valid
- out_ready  input  1  downstream accepts sample
- out_re, out_im  output  DW each  output sample, bit-reversed order
- out_last  output  1  high on the final sample (index N-1) of a frame
- frames_pending  output  2  number of full banks (0..2)
- One clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- Storage: two banks, each N entries × 2·DW bits. Per-bank flag full[b].
- Write side: pointers wbank (1 b) and waddr (LOG2N b). in_ready = !full[wbank]. On in_valid && in_ready: mem[wbank][waddr] <= {in_re,in_im}; waddr++. When waddr == N-1 on accept: full[wbank] <= 1, wbank toggles, waddr <= 0.
- Read side: pointers rbank, raddr. out_valid = full[rbank]. Output data = mem[rbank][bitrev(raddr)], forced to 0 when out_valid is low. out_last = out_valid && raddr == N-1. On out_valid && out_ready: raddr++. At raddr == N-1: full[rbank] <= 0, rbank toggles, raddr <= 0.
- Per-bank state (derived): EMPTY → FILLING (first write) → FULL (Nth write) → DRAINING (first read) → EMPTY (Nth read).
- bitrev: reverse the LOG2N address bits, e.g. LOG2N=3, 1→4, 3→6, 6→3.
- Simultaneous set of full[wbank] and clear of full[rbank] in one cycle is legal. They always target different banks, because writing requires !full and reading requires full.
- frames_pending = full[0] + full[1].
- in_valid is ignored while in_ready is low. Input data is not required to be held stable across a stall.

## Timing
- Reset values: in_ready=1, out_valid=0, out_re=out_im=0, out_last=0, frames_pending=0. All pointers and flags are cleared. Memory contents are not reset.
- Latency: last sample of a frame accepted in cycle k → out_valid=1 in cycle k+1, presenting mem index 0.
- Throughput: with in_valid and out_ready held high, one sample in and one sample out every cycle indefinitely. in_ready never drops.
- Both banks full: in_ready=0 until the first bank finishes draining. in_ready rises in the cycle after the accept of out_last.
- Output held stable while out_valid && !out_ready.
- Reset asserted mid-frame: both partial and full frames are discarded. out_valid drops asynchronously.

## Configuration
- FFT_BITREV_BYPASS_EN defined: adds input port bypass (1 bit).
  - bypass is sampled on the first accepted write of each frame and stored per bank.
  - A bank with bypass set drains in natural order (index = raddr).
  - Changing bypass mid-frame has no effect on the current frame.
- FFT_BITREV_BYPASS_EN undefined: no bypass port; every frame is bit-reversed.

## Structure
- Shared fft_pkg holds:
  - default DW and LOG2N constants
  - complex-sample typedef {re, im}
  - function bitrev(addr, LOG2N)
  - the macro guard name
- Sub-module fft_bitrev_bank: one N-entry storage bank with write port, combinational read port and full flag. Instantiated twice.
- Pointer and handshake logic stays in the top module.

## Test plan
- LOG2N=3, write samples re=0..7 (im=re+100), out_ready=1 → outputs re = 0,4,2,6,1,5,3,7. out_last only on re=7. First out_valid one cycle after in_re=7 is accepted.
- Continuous stream of 4 frames with in_valid=out_ready=1 → in_ready never low. 32 outputs, each frame correctly reordered.
- out_ready=0 while 2 frames are written → frames_pending=2, in_ready=0. A 17th write is ignored. Then out_ready=1 → in_ready returns after the 8th output.
- Random out_ready toggling → out_re/out_im are stable during stalls and no sample is lost or duplicated (scoreboard).
- Reset pulse after 5 writes of a frame, then a fresh full frame → only the fresh frame is output, starting with index 0.
- With FFT_BITREV_BYPASS_EN, frame A with bypass=1 and frame B with bypass=0 → A is output as 0..7, B as 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, sample type and address helper for the FFT bit-reversal reorder buffer.
// Natural-order bypass is enabled by defining the macro FFT_BITREV_BYPASS_EN.
package fft_pkg;

   localparam int FFT_DW        = 16;
   localparam int FFT_LOG2N     = 6;
   localparam int FFT_LOG2N_MAX = 10;

   localparam string FFT_BYPASS_MACRO = "FFT_BITREV_BYPASS_EN";
`ifdef FFT_BITREV_BYPASS_EN
   localparam bit FFT_BYPASS_EN = 1'b1;
`else
   localparam bit FFT_BYPASS_EN = 1'b0;
`endif

   typedef struct packed {
      logic signed [FFT_DW-1:0] re;
      logic signed [FFT_DW-1:0] im;
   } cplx_t;

   // Reverses the low log2n bits of addr; bits at and above log2n come back as zero.
   function automatic logic [FFT_LOG2N_MAX-1:0] bitrev(input logic [FFT_LOG2N_MAX-1:0] addr,
                                                       input int log2n);
      logic [FFT_LOG2N_MAX-1:0] r;
      r = '0;
      for (int i = 0; i < FFT_LOG2N_MAX; i++) begin
         if (i < log2n) begin
            r[4'(log2n - 1 - i)] = addr[4'(i)];
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_bank.sv
// One N-entry sample bank: synchronous write port, combinational read port and full flag.
// With FFT_BITREV_BYPASS_EN the bank also remembers the bypass bit of the frame it holds.
module fft_bitrev_bank
   import fft_pkg::*;
#(
   parameter int DW    = FFT_DW,
   parameter int LOG2N = FFT_LOG2N
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [LOG2N-1:0]  i_waddr,
   input  logic [2*DW-1:0]   i_wdata,
   input  logic              i_set_full,
   input  logic              i_clr_full,
`ifdef FFT_BITREV_BYPASS_EN
   input  logic              i_bypass,
   output logic              o_bypass,
`endif
   input  logic [LOG2N-1:0]  i_raddr,
   output logic [2*DW-1:0]   o_rdata,
   output logic              o_full
);

   localparam int N = 2 ** LOG2N;

   logic [2*DW-1:0] r_mem [N];
   logic            r_full;

   // Sample storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Full flag: set by the last write of a frame, cleared by the last read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_full <= 1'b0;
      end else if (i_set_full) begin
         r_full <= 1'b1;
      end else if (i_clr_full) begin
         r_full <= 1'b0;
      end else begin
         r_full <= r_full;
      end
   end

`ifdef FFT_BITREV_BYPASS_EN
   logic r_bypass;

   // Bypass is latched on the first write of a frame so mid-frame changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bypass <= 1'b0;
      end else if (i_we && (i_waddr == '0)) begin
         r_bypass <= i_bypass;
      end else begin
         r_bypass <= r_bypass;
      end
   end

   assign o_bypass = r_bypass;
`endif

   assign o_rdata = r_mem[i_raddr];
   assign o_full  = r_full;

endmodule

// File: rtl/fft_bitrev_buf.sv
// Ping-pong reorder buffer: frames arrive in natural order and leave in bit-reversed order.
// Optional macro FFT_BITREV_BYPASS_EN adds a per-frame bypass input (natural-order drain).
module fft_bitrev_buf
   import fft_pkg::*;
#(
   parameter int DW    = FFT_DW,
   parameter int LOG2N = FFT_LOG2N
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_re,
   input  logic [DW-1:0] in_im,
`ifdef FFT_BITREV_BYPASS_EN
   input  logic          bypass,
`endif
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_re,
   output logic [DW-1:0] out_im,
   output logic          out_last,
   output logic [1:0]    frames_pending
);

   localparam logic [LOG2N-1:0] ADDR_MAX = '1;
   localparam logic [LOG2N-1:0] ADDR_ONE = {{(LOG2N-1){1'b0}}, 1'b1};

   logic             r_wbank;
   logic [LOG2N-1:0] r_waddr;
   logic             r_rbank;
   logic [LOG2N-1:0] r_raddr;

   logic             w_wr;
   logic             w_wr_last;
   logic             w_rd;
   logic             w_rd_last;
   logic [1:0]       w_full;
   logic [1:0]       w_byp;
   logic             w_natural;
   logic [LOG2N-1:0] w_ridx_rev;
   logic [LOG2N-1:0] w_ridx;
   logic [2*DW-1:0]  w_bank_rdata [2];
   logic [2*DW-1:0]  w_rdata;

   assign in_ready  = ~w_full[r_wbank];
   assign w_wr      = in_valid & in_ready;
   assign w_wr_last = w_wr & (r_waddr == ADDR_MAX);

   assign out_valid = w_full[r_rbank];
   assign w_rd      = out_valid & out_ready;
   assign w_rd_last = w_rd & (r_raddr == ADDR_MAX);

   assign w_ridx_rev = LOG2N'(bitrev(FFT_LOG2N_MAX'(r_raddr), LOG2N));
   assign w_natural  = FFT_BYPASS_EN & w_byp[r_rbank];
   assign w_ridx     = w_natural ? r_raddr : w_ridx_rev;

   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft_bitrev_bank #(
         .DW    (DW),
         .LOG2N (LOG2N)
      ) u_bank (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_we       (w_wr & (r_wbank == 1'(b))),
         .i_waddr    (r_waddr),
         .i_wdata    ({in_re, in_im}),
         .i_set_full (w_wr_last & (r_wbank == 1'(b))),
         .i_clr_full (w_rd_last & (r_rbank == 1'(b))),
`ifdef FFT_BITREV_BYPASS_EN
         .i_bypass   (bypass),
         .o_bypass   (w_byp[b]),
`endif
         .i_raddr    (w_ridx),
         .o_rdata    (w_bank_rdata[b]),
         .o_full     (w_full[b])
      );
   end

`ifndef FFT_BITREV_BYPASS_EN
   assign w_byp = 2'b00;
`endif

   // Write pointer: walks the current fill bank, then hops to the other bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbank <= 1'b0;
         r_waddr <= '0;
      end else if (w_wr_last) begin
         r_wbank <= ~r_wbank;
         r_waddr <= '0;
      end else if (w_wr) begin
         r_wbank <= r_wbank;
         r_waddr <= r_waddr + ADDR_ONE;
      end else begin
         r_wbank <= r_wbank;
         r_waddr <= r_waddr;
      end
   end

   // Read pointer: counts naturally; bit reversal is applied only to the bank address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rbank <= 1'b0;
         r_raddr <= '0;
      end else if (w_rd_last) begin
         r_rbank <= ~r_rbank;
         r_raddr <= '0;
      end else if (w_rd) begin
         r_rbank <= r_rbank;
         r_raddr <= r_raddr + ADDR_ONE;
      end else begin
         r_rbank <= r_rbank;
         r_raddr <= r_raddr;
      end
   end

   // Output data mux, forced to zero whenever nothing valid is presented.
   always_comb begin
      w_rdata = '0;
      if (out_valid) begin
         w_rdata = w_bank_rdata[r_rbank];
      end else begin
         w_rdata = '0;
      end
   end

   assign out_re         = w_rdata[2*DW-1:DW];
   assign out_im         = w_rdata[DW-1:0];
   assign out_last       = out_valid & (r_raddr == ADDR_MAX);
   assign frames_pending = {1'b0, w_full[0]} + {1'b0, w_full[1]};

endmodule

// File: tb/tb_fft_bitrev_buf.sv
// Directed self-checking bench for fft_bitrev_buf with N = 8 (LOG2N = 3), default build.
module tb_fft_bitrev_buf;

   localparam int DW    = 16;
   localparam int LOG2N = 3;
   localparam int N     = 8;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_re;
   logic [DW-1:0] in_im;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_re;
   logic [DW-1:0] out_im;
   logic          out_last;
   logic [1:0]    frames_pending;

   fft_bitrev_buf #(.DW(DW), .LOG2N(LOG2N)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_re          (in_re),
      .in_im          (in_im),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_re         (out_re),
      .out_im         (out_im),
      .out_last       (out_last),
      .frames_pending (frames_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      int          idx;
   } in_t;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic        last;
   } out_t;

   in_t  in_q[$];
   out_t exp_q[$];
   int   br8 [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

   int n_vec = 0;
   int n_err = 0;
   int tcyc = 0;
   int last_acc_cyc = -1;
   int first_vld_cyc = -1;
   bit seen_valid = 1'b0;
   int n_out = 0;
   int first_rdy_nout = -1;
   int n_in_stall = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic push_in(input logic [15:0] base, input int from, input int to);
      for (int i = from; i <= to; i++) begin
         in_t s;
         s.re  = base + 16'(i);
         s.im  = base + 16'(i) + 16'd100;
         s.idx = i;
         in_q.push_back(s);
      end
   endtask

   task automatic push_exp(input logic [15:0] base);
      for (int j = 0; j < N; j++) begin
         out_t o;
         o.re   = base + 16'(br8[j]);
         o.im   = base + 16'(br8[j]) + 16'd100;
         o.last = (j == N - 1);
         exp_q.push_back(o);
      end
   endtask

   // rdy_mode: 0 = out_ready high, 1 = random, 2 = out_ready low
   task automatic run(input int max_cyc, input int rdy_mode, input bit must_drain);
      int          cyc;
      bit          hold_vld;
      logic [31:0] hold_d;
      bit          acc_in;
      cyc      = 0;
      hold_vld = 1'b0;
      hold_d   = 32'h0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
         @(negedge clk);
         in_valid = (in_q.size() > 0);
         if (in_valid) begin
            in_re = in_q[0].re;
            in_im = in_q[0].im;
         end
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
         if (in_valid && !in_ready) n_in_stall++;
         if (in_ready && first_rdy_nout < 0) first_rdy_nout = n_out;
         if (hold_vld) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", {out_re, out_im}, hold_d);
         end
         if (out_valid) begin
            if (!seen_valid) begin
               seen_valid    = 1'b1;
               first_vld_cyc = tcyc;
            end
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("extra_output", 32'd1, 32'd0);
               end else begin
                  out_t e;
                  e = exp_q.pop_front();
                  check("out_re", 32'(out_re), 32'(e.re));
                  check("out_im", 32'(out_im), 32'(e.im));
                  check("out_last", 32'(out_last), 32'(e.last));
               end
               n_out++;
            end
         end else begin
            check("idle_data", {out_re, out_im, 15'd0, out_last}, 32'h0);
         end
         hold_vld = out_valid && !out_ready;
         hold_d   = {out_re, out_im};
         acc_in   = in_valid && in_ready;
         @(posedge clk);
         tcyc++;
         if (acc_in) begin
            if (in_q[0].idx == N - 1) last_acc_cyc = tcyc;
            void'(in_q.pop_front());
         end
         cyc++;
      end
      in_valid = 1'b0;
      if (must_drain) check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_re     = 16'h0;
      in_im     = 16'h0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", {out_re, out_im}, 32'h0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_pending", 32'(frames_pending), 32'd0);
      rst_n = 1'b1;

      // Single frame 0..7, im = re + 100
      seen_valid = 1'b0;
      push_in(16'd0, 0, 7);
      push_exp(16'd0);
      run(100, 0, 1'b1);
      check("latency", 32'(first_vld_cyc), 32'(last_acc_cyc));

      // Four back-to-back frames at full rate
      n_in_stall = 0;
      n_out      = 0;
      push_in(16'h0100, 0, 7); push_exp(16'h0100);
      push_in(16'h0200, 0, 7); push_exp(16'h0200);
      push_in(16'h0300, 0, 7); push_exp(16'h0300);
      push_in(16'h0400, 0, 7); push_exp(16'h0400);
      run(200, 0, 1'b1);
      check("stream_in_stall", 32'(n_in_stall), 32'd0);
      check("stream_nout", 32'(n_out), 32'd32);

      // Both banks full, 17th write must wait
      push_in(16'h1000, 0, 7);
      push_in(16'h2000, 0, 7);
      push_in(16'h3000, 0, 0);
      push_exp(16'h1000);
      push_exp(16'h2000);
      run(20, 2, 1'b0);
      @(negedge clk);
      check("full_pending", 32'(frames_pending), 32'd2);
      check("full_in_ready", 32'(in_ready), 32'd0);
      check("full_17th_left", 32'(in_q.size()), 32'd1);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_out_re", 32'(out_re), 32'h1000);
      push_in(16'h3000, 1, 7);
      push_exp(16'h3000);
      n_out          = 0;
      first_rdy_nout = -1;
      run(200, 0, 1'b1);
      check("ready_after_nout", 32'(first_rdy_nout), 32'd8);

      // Random backpressure with wrapping negative data
      push_in(16'h8000, 0, 7); push_exp(16'h8000);
      push_in(16'hFFF0, 0, 7); push_exp(16'hFFF0);
      push_in(16'h7FFC, 0, 7); push_exp(16'h7FFC);
      run(600, 1, 1'b1);

      // Reset with one full and one partial frame stored
      push_in(16'h0500, 0, 7);
      push_in(16'h0600, 0, 4);
      run(13, 2, 1'b0);
      @(negedge clk);
      check("prerst_pending", 32'(frames_pending), 32'd1);
      check("prerst_accepted", 32'(in_q.size()), 32'd0);
      rst_n = 1'b0;
      #1;
      check("async_out_valid", 32'(out_valid), 32'd0);
      check("async_pending", 32'(frames_pending), 32'd0);
      in_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      check("postrst_in_ready", 32'(in_ready), 32'd1);
      push_in(16'h0700, 0, 7);
      push_exp(16'h0700);
      run(100, 0, 1'b1);
      @(negedge clk);
      check("end_pending", 32'(frames_pending), 32'd0);
      check("end_out_valid", 32'(out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
